// File: rtl/nios_cpu_debug_mem_seq.sv
// Debug memory sequencer: turns OCI memory command pulses into single-word reads/writes with address auto-increment.
// Latency: strobe from the cycle after acceptance; monitor_ready 2 clocks after the command at minimum (no stall).
// Backpressure: holds the strobe while m_waitrequest=1; commands arriving while busy are dropped and flag monitor_error.
// Optional feature macro: DBG_SEQ_TIMEOUT_EN (abort a transaction after TIMEOUT_CYCLES stall cycles).
module nios_cpu_debug_mem_seq #(
  parameter int AW             = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          take_action_ocimem_a,
  input  logic          take_no_action_ocimem_a,
  input  logic          take_action_ocimem_b,
  input  logic [37:0]   jdo,
  output logic [AW-1:0] m_address,
  output logic          m_read,
  output logic          m_write,
  output logic [31:0]   m_writedata,
  input  logic [31:0]   m_readdata,
  input  logic          m_waitrequest,
  output logic [31:0]   MonDReg,
  output logic          monitor_ready,
  output logic          monitor_error,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] addr;
  logic          any_cmd;
  logic          start_rd, start_wr, load_addr, load_only, clr_err;
  logic          overrun, done, abort;
  logic          timeout_hit;

  // Strobes and busy decode straight from the state register, so an async reset drops them at once.
  assign m_read    = (state == RD);
  assign m_write   = (state == WR);
  assign busy      = (state != IDLE);
  assign m_address = addr;
  assign any_cmd   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;

  // jdo[35] and jdo[2:0] carry no information for this block.
  logic unused_bits;
  assign unused_bits = ^{jdo[35], jdo[2:0]};

`ifdef DBG_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] stall_cnt;

  // The stall that would bring the count to TIMEOUT_CYCLES aborts the transaction at that edge.
  assign timeout_hit = m_waitrequest && (stall_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Count waitrequest stall cycles of the transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (start_rd || start_wr) begin
      stall_cnt <= '0;
    end else if (busy && m_waitrequest) begin
      stall_cnt <= stall_cnt + CW'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign timeout_hit    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Command decode with priority ocimem_b > no_action_a > ocimem_a, and transaction completion.
  always_comb begin
    state_nxt = state;
    start_rd  = 1'b0;
    start_wr  = 1'b0;
    load_addr = 1'b0;
    load_only = 1'b0;
    clr_err   = 1'b0;
    overrun   = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (take_action_ocimem_b) begin
          start_wr  = 1'b1;
          state_nxt = WR;
        end else if (take_no_action_ocimem_a) begin
          start_rd  = 1'b1;
          state_nxt = RD;
        end else if (take_action_ocimem_a) begin
          load_addr = 1'b1;
          clr_err   = jdo[36];
          if (jdo[37]) begin
            start_rd  = 1'b1;
            state_nxt = RD;
          end else begin
            load_only = 1'b1;
          end
        end
      end
      RD, WR: begin
        overrun = any_cmd;
        if (!m_waitrequest) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (timeout_hit) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: address, write data, read capture and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr          <= '0;
      m_writedata   <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      if (load_addr) addr <= jdo[AW-1:0];
      else if (done) addr <= addr + AW'(1);

      if (start_wr) m_writedata <= jdo[34:3];

      if (done && (state == RD)) MonDReg <= m_readdata;

      if (start_rd || start_wr)          monitor_ready <= 1'b0;
      else if (done || abort || load_only) monitor_ready <= 1'b1;

      if (overrun || abort) monitor_error <= 1'b1;
      else if (clr_err)     monitor_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nios_cpu_debug_mem_seq.sv
// Bench for the debug memory sequencer: expected bus transactions are queued at command issue
// and popped when the DUT completes a bus cycle; status outputs checked against a small model.
module tb_nios_cpu_debug_mem_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        take_action_ocimem_a = 1'b0;
  logic        take_no_action_ocimem_a = 1'b0;
  logic        take_action_ocimem_b = 1'b0;
  logic [37:0] jdo = '0;
  logic [7:0]  m_address;
  logic        m_read, m_write;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic        m_waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error, busy;

  typedef struct packed {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          strobes = 0;
  int          stall_target = 0;
  int          stall_cnt;
  logic [31:0] rd_value = '0;
  logic [31:0] last_rd = '0;
  logic [7:0]  maddr = '0;
  logic        merr = 1'b0;

  always #5 clk = ~clk;

  nios_cpu_debug_mem_seq #(.AW(8), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .jdo(jdo),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error), .busy(busy)
  );

  // Slave model: stall stall_target cycles per bus cycle, return rd_value.
  assign m_readdata    = rd_value;
  assign m_waitrequest = (m_read || m_write) && (stall_cnt < stall_target);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_cnt <= 0;
    else          stall_cnt <= m_waitrequest ? stall_cnt + 1 : 0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] ja(input logic rd, input logic clr, input logic [7:0] a);
    return {rd, clr, 28'd0, a};
  endfunction

  function automatic logic [37:0] jb(input logic [31:0] d);
    return {3'b000, d, 3'b000};
  endfunction

  // One clock: sample at the falling edge, score any completing bus cycle.
  task automatic step();
    txn_t t;
    @(negedge clk);
    if (reset_n && (m_read || m_write)) begin
      strobes++;
      if (!m_waitrequest) begin
        if (exp_q.size() == 0) begin
          check("unexpected_txn", 32'(exp_q.size()), 32'd1);
        end else begin
          t = exp_q.pop_front();
          check("txn_kind", 32'(m_write), 32'(t.wr));
          check("txn_addr", 32'(m_address), 32'(t.addr));
          if (t.wr) check("txn_wdata", m_writedata, t.data);
        end
      end
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // kind: 0 = ocimem_a, 1 = no_action_a, 2 = ocimem_b. extra_a raises ocimem_a alongside.
  task automatic do_cmd(input int kind, input logic [37:0] j, input int stalls, input logic extra_a);
    logic xfer, rd;
    int   n;
    xfer = 1'b1;
    rd   = 1'b0;
    case (kind)
      2: begin
        exp_q.push_back('{1'b1, maddr, j[34:3]});
        maddr++;
      end
      1: begin
        rd = 1'b1;
        exp_q.push_back('{1'b0, maddr, rd_value});
        maddr++;
      end
      default: begin
        maddr = j[7:0];
        if (j[36]) merr = 1'b0;
        xfer = j[37];
        rd   = j[37];
        if (j[37]) begin
          exp_q.push_back('{1'b0, maddr, rd_value});
          maddr++;
        end
      end
    endcase
    strobes      = 0;
    stall_target = stalls;
    jdo          = j;
    take_action_ocimem_a    = (kind == 0) || extra_a;
    take_no_action_ocimem_a = (kind == 1);
    take_action_ocimem_b    = (kind == 2);
    step();
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
    wait_idle(n);
    check("latency", 32'(n), xfer ? 32'(stalls + 1) : 32'd0);
    check("strobe_cycles", 32'(strobes), xfer ? 32'(stalls + 1) : 32'd0);
    check("monitor_ready", 32'(monitor_ready), 32'd1);
    check("monitor_error", 32'(monitor_error), 32'(merr));
    check("q_empty", 32'(exp_q.size()), 32'd0);
    if (rd) last_rd = rd_value;
    check("MonDReg", MonDReg, last_rd);
  endtask

  initial begin
    int n;
    repeat (3) step();
    check("rst_ctrl", 32'({m_read, m_write, busy, monitor_ready, monitor_error}), 32'd0);
    check("rst_addr", 32'(m_address), 32'd0);
    check("rst_wdata", m_writedata, 32'd0);
    check("rst_mondreg", MonDReg, 32'd0);
    reset_n = 1'b1;
    step();

    // Address load only, then a stalled write lands at the loaded address.
    do_cmd(0, ja(1'b0, 1'b0, 8'h10), 0, 1'b0);
    do_cmd(2, jb(32'hDEADBEEF), 2, 1'b0);
    check("addr_after_wr", 32'(m_address), 32'h11);

    // Load 0xFF with read: data two clocks after the pulse, then wrap to 0.
    rd_value = 32'h12345678;
    do_cmd(0, ja(1'b1, 1'b0, 8'hFF), 0, 1'b0);
    rd_value = 32'h0BADF00D;
    do_cmd(1, '0, 1, 1'b0);

    // Overrun: a second read pulse while busy is dropped and flags an error.
    rd_value = 32'hA5A55A5A;
    exp_q.push_back('{1'b0, maddr, rd_value});
    maddr++;
    strobes = 0;
    stall_target = 3;
    take_no_action_ocimem_a = 1'b1;
    step();
    take_no_action_ocimem_a = 1'b0;
    step();
    take_no_action_ocimem_a = 1'b1;
    step();
    take_no_action_ocimem_a = 1'b0;
    wait_idle(n);
    merr = 1'b1;
    last_rd = rd_value;
    check("ovr_error", 32'(monitor_error), 32'd1);
    check("ovr_mondreg", MonDReg, rd_value);
    check("ovr_strobes", 32'(strobes), 32'd4);
    check("ovr_q_empty", 32'(exp_q.size()), 32'd0);
    do_cmd(0, ja(1'b0, 1'b1, 8'h40), 0, 1'b0);

    // Simultaneous ocimem_b and ocimem_a: the write wins, no load, no error.
    do_cmd(2, jb(32'hCAFEF00D), 1, 1'b1);

    // Mixed traffic.
    for (int i = 0; i < 6; i++) begin
      rd_value = $urandom;
      do_cmd(int'($urandom_range(1, 2)), jb($urandom), int'($urandom_range(0, 3)), 1'b0);
    end

`ifdef DBG_SEQ_TIMEOUT_EN
    // Stuck slave: abort after TIMEOUT_CYCLES stalls, address and MonDReg untouched.
    rd_value = 32'hBADBAD00;
    strobes = 0;
    stall_target = 1000;
    take_no_action_ocimem_a = 1'b1;
    step();
    take_no_action_ocimem_a = 1'b0;
    wait_idle(n);
    merr = 1'b1;
    check("to_strobes", 32'(strobes), 32'd4);
    check("to_error", 32'(monitor_error), 32'd1);
    check("to_ready", 32'(monitor_ready), 32'd1);
    check("to_mondreg", MonDReg, last_rd);
    check("to_addr", 32'(m_address), 32'(maddr));
    rd_value = 32'h600DCAFE;
    do_cmd(1, '0, 0, 1'b0);
`endif

    // Async reset in the middle of a stalled write.
    strobes = 0;
    stall_target = 1000;
    jdo = jb(32'h11112222);
    take_action_ocimem_b = 1'b1;
    step();
    take_action_ocimem_b = 1'b0;
    check("wr_active", 32'(m_write), 32'd1);
    #2 reset_n = 1'b0;
    #1 check("async_drop", 32'({m_write, busy}), 32'd0);
    exp_q.delete();
    maddr = '0;
    merr = 1'b0;
    last_rd = '0;
    step();
    reset_n = 1'b1;
    step();
    check("post_rst_ctrl", 32'({m_read, m_write, busy, monitor_ready, monitor_error}), 32'd0);
    check("post_rst_addr", 32'(m_address), 32'd0);
    check("post_rst_mondreg", MonDReg, 32'd0);
    check("post_rst_wdata", m_writedata, 32'd0);
    rd_value = 32'h13579BDF;
    do_cmd(1, '0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
